mips_cpu_alu: RTL and testbench
===============================

Name: mips_cpu_alu

Overview:
- Execute unit of the multi-cycle MIPS-I CPU (mips_cpu_harvard).
- Combinationally computes the result, branch condition, carry and zero flags for the current instruction from its decoded fields and the rs/rt register values.
- Owns the clocked HI/LO registers used by MULT/DIV/MFHI/MFLO/MTHI/MTLO.

Parameters:
- none

Ports:
- clk  in  1  system clock; HI/LO update on rising edge
- reset  in  1  synchronous, active-high; clears HI/LO
- hilo_en  in  1  HI/LO write strobe; CPU asserts for exactly one cycle per MULT/DIV/MTxx instruction
- alu_op  in  6  funct field instr[5:0]
- opcode  in  6  instr[31:26]
- shamt  in  5  instr[10:6]
- immediate  in  16  instr[15:0]
- regimm_rt  in  5  instr[20:16]; selects the REGIMM branch variant
- a  in  32  rs value
- b  in  32  rt value
- carry_in  in  1  registered carry from the previous instruction
- branch  out  1  branch condition true
- alu_out  out  32  result or memory address
- carry_out  out  1  carry flag for the CPU carry register
- zero_flag  out  1  alu_out == 0

Behaviour:
- All outputs are combinational; zero added latency. Only HI/LO are state.
- Immediates: sext = {{16{imm[15]}}, imm}; zext = {16'b0, imm}.
- Default for any unlisted opcode/funct, including J and JAL: alu_out=0, branch=0, carry_out=carry_in, HI/LO untouched.
- carry_out:
  - ADD/ADDU/ADDIU: bit 32 of the 33-bit unsigned sum.
  - SUB/SUBU: bit 32 of a + ~b + 1, so it is 1 when a >= b unsigned.
  - Every other op: carry_out = carry_in.
  - carry_in is never added into a sum.
- opcode 000000 (R-type), by alu_op:
  - 000000 SLL: b << shamt
  - 000010 SRL: b >> shamt, logical
  - 000011 SRA: b >>> shamt, arithmetic
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: as above, shift amount = a[4:0]
  - 001000 JR, 001001 JALR: alu_out = a; branch = 0
  - 010000 MFHI: HI. 010010 MFLO: LO
  - 010001 MTHI: HI <= a. 010011 MTLO: LO <= a
  - 011000 MULT: {HI,LO} <= signed a*b (64-bit). 011001 MULTU: unsigned a*b
  - 011010 DIV: LO <= signed quotient, HI <= remainder; truncate toward zero, remainder takes the sign of the dividend. 011011 DIVU: unsigned
  - For MTHI/MTLO/MULT/MULTU/DIV/DIVU, alu_out = 0.
  - 100000 ADD, 100001 ADDU: a+b; no overflow trap
  - 100010 SUB, 100011 SUBU: a-b
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT: signed a<b -> 1, else 0. 101011 SLTU: unsigned compare
- Immediate and memory opcodes:
  - 001001 ADDIU: a+sext
  - 001010 SLTI: signed a < sext. 001011 SLTIU: unsigned a < sext
  - 001100 ANDI, 001101 ORI, 001110 XORI: a op zext
  - 001111 LUI: {imm, 16'b0}
  - Loads/stores 100000–100110 and 101000/101001/101011: alu_out = a+sext (byte address); carry_out = carry_in
- Branches (alu_out = a-b for BEQ/BNE, a for the others):
  - 000100 BEQ: branch = (a==b). 000101 BNE: branch = (a!=b)
  - 000110 BLEZ: signed a<=0. 000111 BGTZ: signed a>0
  - 000001 REGIMM: regimm_rt 00000 BLTZ or 10000 BLTZAL -> branch = a[31]; 00001 BGEZ or 10001 BGEZAL -> branch = !a[31]; other values -> branch = 0
- HI/LO timing:
  - Update only on a rising edge when hilo_en=1 and the decoded op is MULT/MULTU/DIV/DIVU/MTHI/MTLO.
  - DIV/DIVU with b==0: HI/LO unchanged.
  - MFHI/MFLO read the pre-edge value. A MULT result is readable on the cycle after its write edge.
- Reset:
  - Reset=1 at an edge sets HI=LO=0 and takes priority over hilo_en.
  - Combinational outputs are unaffected by reset except through HI/LO.

Test Plan:
- ADDU a=FFFFFFFF, b=00000001 -> alu_out=0, carry_out=1, zero_flag=1. SUBU a=5, b=7 -> FFFFFFFE, carry_out=0.
- SRA b=80000000, shamt=4 -> F8000000. SRLV a=4, same b -> 08000000. LUI imm=1234 -> 12340000. SLTI a=FFFFFFFF, imm=0000 -> 1. SLTIU a=1, imm=FFFF -> 1.
- Branches: BEQ a=b=7 -> branch=1. BGTZ a=0 -> branch=0. REGIMM rt=00001, a=0 -> branch=1. rt=00000, a=80000000 -> branch=1.
- MULT a=FFFFFFFE (-2), b=3 with hilo_en pulse; then MFHI -> FFFFFFFF, MFLO -> FFFFFFFA. DIV a=-7, b=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU b=0 after MTLO a=AAAA5555 -> LO still AAAA5555. MTHI with hilo_en=0 -> HI unchanged.
- Reset=1 with hilo_en=1 and MTHI a=1 -> HI=0. Unknown opcode 111111 with carry_in=1 -> alu_out=0, branch=0, carry_out=1.

Source files
------------

// File: rtl/mips_cpu_alu_if.sv
// Execute-unit bus of the multi-cycle MIPS-I CPU: decoded instruction fields
// and operands toward the ALU, result and flags back to the CPU.
interface mips_cpu_alu_if;
  logic        hilo_en;
  logic [5:0]  alu_op;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [4:0]  regimm_rt;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic        branch;
  logic [31:0] alu_out;
  logic        carry_out;
  logic        zero_flag;

  // CPU side: drives the instruction fields and operands
  modport master (
    output hilo_en, alu_op, opcode, shamt, immediate, regimm_rt, a, b, carry_in,
    input  branch, alu_out, carry_out, zero_flag
  );

  // ALU side: consumes the fields, returns result and flags
  modport slave (
    input  hilo_en, alu_op, opcode, shamt, immediate, regimm_rt, a, b, carry_in,
    output branch, alu_out, carry_out, zero_flag
  );
endinterface

// File: rtl/mips_cpu_alu.sv
// MIPS-I execute unit: combinational result/branch/carry/zero plus the
// clocked HI/LO pair written by MULT(U), DIV(U), MTHI and MTLO.
module mips_cpu_alu (
  input  logic           clk,
  input  logic           reset,
  mips_cpu_alu_if.slave  bus
);

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        hilo_wr;

  logic [31:0] sext, zext;
  logic [32:0] sum_ab, diff_ab, sum_imm;
  logic [31:0] sra_sh, sra_var;
  logic [63:0] mul_s, mul_u;
  logic [31:0] b_nz, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        slt_s, sltu_s, slti_s, sltiu_s;

  logic [31:0] alu_out_c;
  logic        branch_c;
  logic        carry_c;

  assign sext = {{16{bus.immediate[15]}}, bus.immediate};
  assign zext = {16'd0, bus.immediate};

  // carry_in is never folded into a sum; subtraction is a + ~b + 1
  assign sum_ab  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ab = {1'b0, bus.a} + {1'b0, ~bus.b} + 33'd1;
  assign sum_imm = {1'b0, bus.a} + {1'b0, sext};

  assign sra_sh  = $unsigned($signed(bus.b) >>> bus.shamt);
  assign sra_var = $unsigned($signed(bus.b) >>> bus.a[4:0]);

  // Low 64 bits of the product of sign-extended operands equal the signed product
  assign mul_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign mul_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divider built on magnitudes so truncation and remainder sign are explicit;
  // a zero divisor is steered to 1 only to keep the datapath defined (no write then)
  assign b_nz  = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign a_mag = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign b_mag = b_nz[31]  ? (32'd0 - b_nz)  : b_nz;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (bus.a[31] ^ b_nz[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = bus.a[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u   = bus.a / b_nz;
  assign r_u   = bus.a % b_nz;

  assign slt_s   = ($signed(bus.a) < $signed(bus.b));
  assign sltu_s  = (bus.a < bus.b);
  assign slti_s  = ($signed(bus.a) < $signed(sext));
  assign sltiu_s = (bus.a < sext);

  // Decode the instruction into result, branch condition, carry and HI/LO next state
  always_comb begin
    alu_out_c = 32'd0;
    branch_c  = 1'b0;
    carry_c   = bus.carry_in;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hilo_wr   = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.alu_op)
          FN_SLL:   alu_out_c = bus.b << bus.shamt;
          FN_SRL:   alu_out_c = bus.b >> bus.shamt;
          FN_SRA:   alu_out_c = sra_sh;
          FN_SLLV:  alu_out_c = bus.b << bus.a[4:0];
          FN_SRLV:  alu_out_c = bus.b >> bus.a[4:0];
          FN_SRAV:  alu_out_c = sra_var;
          FN_JR,
          FN_JALR:  alu_out_c = bus.a;
          FN_MFHI:  alu_out_c = hi_q;
          FN_MFLO:  alu_out_c = lo_q;
          FN_MTHI: begin
            hi_d    = bus.a;
            hilo_wr = 1'b1;
          end
          FN_MTLO: begin
            lo_d    = bus.a;
            hilo_wr = 1'b1;
          end
          FN_MULT: begin
            hi_d    = mul_s[63:32];
            lo_d    = mul_s[31:0];
            hilo_wr = 1'b1;
          end
          FN_MULTU: begin
            hi_d    = mul_u[63:32];
            lo_d    = mul_u[31:0];
            hilo_wr = 1'b1;
          end
          FN_DIV: begin
            hi_d    = r_s;
            lo_d    = q_s;
            hilo_wr = (bus.b != 32'd0);
          end
          FN_DIVU: begin
            hi_d    = r_u;
            lo_d    = q_u;
            hilo_wr = (bus.b != 32'd0);
          end
          FN_ADD,
          FN_ADDU: begin
            alu_out_c = sum_ab[31:0];
            carry_c   = sum_ab[32];
          end
          FN_SUB,
          FN_SUBU: begin
            alu_out_c = diff_ab[31:0];
            carry_c   = diff_ab[32];
          end
          FN_AND:   alu_out_c = bus.a & bus.b;
          FN_OR:    alu_out_c = bus.a | bus.b;
          FN_XOR:   alu_out_c = bus.a ^ bus.b;
          FN_NOR:   alu_out_c = ~(bus.a | bus.b);
          FN_SLT:   alu_out_c = {31'd0, slt_s};
          FN_SLTU:  alu_out_c = {31'd0, sltu_s};
          default:  alu_out_c = 32'd0;
        endcase
      end
      OP_ADDIU: begin
        alu_out_c = sum_imm[31:0];
        carry_c   = sum_imm[32];
      end
      OP_SLTI:  alu_out_c = {31'd0, slti_s};
      OP_SLTIU: alu_out_c = {31'd0, sltiu_s};
      OP_ANDI:  alu_out_c = bus.a & zext;
      OP_ORI:   alu_out_c = bus.a | zext;
      OP_XORI:  alu_out_c = bus.a ^ zext;
      OP_LUI:   alu_out_c = {bus.immediate, 16'd0};
      // Loads and stores: byte address, carry passes through
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110,
      6'b101000, 6'b101001, 6'b101011: alu_out_c = sum_imm[31:0];
      OP_BEQ: begin
        alu_out_c = diff_ab[31:0];
        branch_c  = (bus.a == bus.b);
      end
      OP_BNE: begin
        alu_out_c = diff_ab[31:0];
        branch_c  = (bus.a != bus.b);
      end
      OP_BLEZ: begin
        alu_out_c = bus.a;
        branch_c  = bus.a[31] | (bus.a == 32'd0);
      end
      OP_BGTZ: begin
        alu_out_c = bus.a;
        branch_c  = ~bus.a[31] & (bus.a != 32'd0);
      end
      OP_REGIMM: begin
        alu_out_c = bus.a;
        case (bus.regimm_rt)
          5'b00000, 5'b10000: branch_c = bus.a[31];
          5'b00001, 5'b10001: branch_c = ~bus.a[31];
          default:            branch_c = 1'b0;
        endcase
      end
      default: alu_out_c = 32'd0;
    endcase
  end

  assign bus.alu_out   = alu_out_c;
  assign bus.branch    = branch_c;
  assign bus.carry_out = carry_c;
  assign bus.zero_flag = (alu_out_c == 32'd0);

  // HI/LO state: reset wins, otherwise commit on the strobe for a writing op
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (bus.hilo_en && hilo_wr) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end else begin
      hi_q <= hi_q;
      lo_q <= lo_q;
    end
  end

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Directed-vector bench for mips_cpu_alu with hand-computed expectations.
module tb_mips_cpu_alu;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mips_cpu_alu_if alu_if ();

  mips_cpu_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic set_fields(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [4:0] rt,
                            input logic [31:0] av, input logic [31:0] bv, input logic cin);
    alu_if.opcode    = op;
    alu_if.alu_op    = fn;
    alu_if.shamt     = sh;
    alu_if.immediate = imm;
    alu_if.regimm_rt = rt;
    alu_if.a         = av;
    alu_if.b         = bv;
    alu_if.carry_in  = cin;
  endtask

  // Combinational vector: apply mid-cycle, settle, then the caller checks
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [4:0] rt,
                       input logic [31:0] av, input logic [31:0] bv, input logic cin);
    @(negedge clk);
    set_fields(op, fn, sh, imm, rt, av, bv, cin);
    #1;
  endtask

  // HI/LO-writing vector with an optional one-cycle strobe across a rising edge
  task automatic hilo_op(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv,
                         input logic en);
    @(negedge clk);
    set_fields(6'd0, fn, 5'd0, 16'd0, 5'd0, av, bv, 1'b0);
    alu_if.hilo_en = en;
    @(posedge clk);
    #1;
    alu_if.hilo_en = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(6'd0, 6'b010000, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk({tag, "_hi"}, alu_if.alu_out, exp_hi);
    drive(6'd0, 6'b010010, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk({tag, "_lo"}, alu_if.alu_out, exp_lo);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    alu_if.hilo_en = 1'b0;
    set_fields(6'd0, 6'd0, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    read_hilo("reset", 32'h0000_0000, 32'h0000_0000);

    // ADDU overflow wraps to zero with carry
    drive(6'd0, 6'b100001, 5'd0, 16'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("addu_out", alu_if.alu_out, 32'h0000_0000);
    chk("addu_carry", {31'd0, alu_if.carry_out}, 32'd1);
    chk("addu_zero", {31'd0, alu_if.zero_flag}, 32'd1);

    // SUBU borrow and no-borrow cases
    drive(6'd0, 6'b100011, 5'd0, 16'd0, 5'd0, 32'd5, 32'd7, 1'b1);
    chk("subu_out", alu_if.alu_out, 32'hFFFF_FFFE);
    chk("subu_carry0", {31'd0, alu_if.carry_out}, 32'd0);
    drive(6'd0, 6'b100011, 5'd0, 16'd0, 5'd0, 32'd7, 32'd5, 1'b0);
    chk("subu_carry1", {31'd0, alu_if.carry_out}, 32'd1);

    // Shifts
    drive(6'd0, 6'b000011, 5'd4, 16'd0, 5'd0, 32'd0, 32'h8000_0000, 1'b0);
    chk("sra", alu_if.alu_out, 32'hF800_0000);
    drive(6'd0, 6'b000110, 5'd0, 16'd0, 5'd0, 32'd4, 32'h8000_0000, 1'b0);
    chk("srlv", alu_if.alu_out, 32'h0800_0000);
    drive(6'd0, 6'b000000, 5'd31, 16'd0, 5'd0, 32'd0, 32'h0000_0001, 1'b0);
    chk("sll31", alu_if.alu_out, 32'h8000_0000);

    // Immediates
    drive(6'b001111, 6'd0, 5'd0, 16'h1234, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("lui", alu_if.alu_out, 32'h1234_0000);
    drive(6'b001010, 6'd0, 5'd0, 16'h0000, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    chk("slti", alu_if.alu_out, 32'h0000_0001);
    drive(6'b001011, 6'd0, 5'd0, 16'hFFFF, 5'd0, 32'h0000_0001, 32'd0, 1'b0);
    chk("sltiu", alu_if.alu_out, 32'h0000_0001);
    drive(6'b001100, 6'd0, 5'd0, 16'hFF00, 5'd0, 32'hFFFF_0F0F, 32'd0, 1'b0);
    chk("andi", alu_if.alu_out, 32'h0000_0F00);

    // Compares and logic
    drive(6'd0, 6'b101010, 5'd0, 16'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("slt", alu_if.alu_out, 32'h0000_0001);
    drive(6'd0, 6'b101011, 5'd0, 16'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("sltu", alu_if.alu_out, 32'h0000_0000);
    drive(6'd0, 6'b100111, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("nor", alu_if.alu_out, 32'hFFFF_FFFF);

    // Load address with carry pass-through
    drive(6'b100011, 6'd0, 5'd0, 16'hFFFC, 5'd0, 32'h0000_1000, 32'd0, 1'b1);
    chk("lw_addr", alu_if.alu_out, 32'h0000_0FFC);
    chk("lw_carry", {31'd0, alu_if.carry_out}, 32'd1);

    // Branches
    drive(6'b000100, 6'd0, 5'd0, 16'd0, 5'd0, 32'd7, 32'd7, 1'b0);
    chk("beq", {31'd0, alu_if.branch}, 32'd1);
    chk("beq_zero", {31'd0, alu_if.zero_flag}, 32'd1);
    drive(6'b000111, 6'd0, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("bgtz0", {31'd0, alu_if.branch}, 32'd0);
    drive(6'b000110, 6'd0, 5'd0, 16'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("blez0", {31'd0, alu_if.branch}, 32'd1);
    drive(6'b000001, 6'd0, 5'd0, 16'd0, 5'b00001, 32'd0, 32'd0, 1'b0);
    chk("bgez", {31'd0, alu_if.branch}, 32'd1);
    drive(6'b000001, 6'd0, 5'd0, 16'd0, 5'b00000, 32'h8000_0000, 32'd0, 1'b0);
    chk("bltz", {31'd0, alu_if.branch}, 32'd1);
    drive(6'b000001, 6'd0, 5'd0, 16'd0, 5'b00010, 32'h8000_0000, 32'd0, 1'b0);
    chk("regimm_other", {31'd0, alu_if.branch}, 32'd0);

    // MULT -2 * 3 = -6
    hilo_op(6'b011000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    chk("mult_out", alu_if.alu_out, 32'h0000_0000);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU max * max
    hilo_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // DIV -7 / 2: quotient -3, remainder -1
    hilo_op(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU by zero leaves LO as written by MTLO
    hilo_op(6'b010011, 32'hAAAA_5555, 32'd0, 1'b1);
    hilo_op(6'b011011, 32'h0000_0009, 32'd0, 1'b1);
    read_hilo("divu0", 32'hFFFF_FFFF, 32'hAAAA_5555);

    // MTHI without strobe is ignored
    hilo_op(6'b010001, 32'h1234_5678, 32'd0, 1'b0);
    read_hilo("mthi_noen", 32'hFFFF_FFFF, 32'hAAAA_5555);

    // Reset beats a simultaneous MTHI strobe
    @(negedge clk);
    set_fields(6'd0, 6'b010001, 5'd0, 16'd0, 5'd0, 32'd1, 32'd0, 1'b0);
    alu_if.hilo_en = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    alu_if.hilo_en = 1'b0;
    reset = 1'b0;
    read_hilo("reset_pri", 32'h0000_0000, 32'h0000_0000);

    // Unknown opcode: zero result, carry passes through
    drive(6'b111111, 6'd0, 5'd0, 16'hFFFF, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    chk("unk_out", alu_if.alu_out, 32'h0000_0000);
    chk("unk_branch", {31'd0, alu_if.branch}, 32'd0);
    chk("unk_carry", {31'd0, alu_if.carry_out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
